// File: rtl/output_buffer_pkg.sv
// Shared sizing, mode codes and state encoding for the output buffer slice.
package output_buffer_pkg;
    localparam int N_DIM_ARRAY           = 4;
    localparam int N_DIM_ARRAY_LOG       = 2;
    localparam int OUTPUT_DATA_WIDTH     = 8;
    localparam int MAXIMUM_DILATION_BITS = 8;

    localparam logic [2:0] MODE_FC  = 3'd0;
    localparam logic [2:0] MODE_CNN = 3'd1;
    localparam logic [2:0] MODE_EWS = 3'd3;

    localparam int ROW_W = N_DIM_ARRAY * OUTPUT_DATA_WIDTH;
    localparam int CNT_W = N_DIM_ARRAY_LOG + 1;

    typedef logic signed [OUTPUT_DATA_WIDTH-1:0] word_t;
    typedef enum logic {ST_IDLE, ST_DRAIN} ob_state_e;
endpackage

// File: rtl/output_lane_select.sv
// Maps the held row onto the beat lanes: lane j carries word ptr+j while j < k, else zero.
module output_lane_select
    import output_buffer_pkg::*;
(
    input  logic [ROW_W-1:0]           words,
    input  logic [N_DIM_ARRAY_LOG-1:0] ptr,
    input  logic [CNT_W-1:0]           k,
    output logic [ROW_W-1:0]           serial_output,
    output logic [N_DIM_ARRAY-1:0]     out_word_mask
);
    logic [N_DIM_ARRAY_LOG-1:0] idx;
    word_t                      lane;

    always_comb begin
        serial_output = '0;
        out_word_mask = '0;
        idx           = '0;
        lane          = '0;
        for (int j = 0; j < N_DIM_ARRAY; j++) begin
            // Word index wraps modulo the row length.
            idx  = ptr + N_DIM_ARRAY_LOG'(j);
            lane = word_t'(words[int'(idx)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]);
            if (CNT_W'(j) < k) begin
                serial_output[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = lane;
                out_word_mask[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_buffer.sv
// Write-back buffer: captures one PE-array row and drains it as masked beats under valid/ready.
module output_buffer
    import output_buffer_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [2:0]                       mode,
    input  logic                             load,
    output logic                             load_ready,
    input  logic [ROW_W-1:0]                 parallel_output_array,
    input  logic [MAXIMUM_DILATION_BITS-1:0] shift_output_buffer,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROW_W-1:0]                 serial_output,
    output logic [N_DIM_ARRAY-1:0]           out_word_mask,
    output logic                             busy
);
    ob_state_e                  state_q;
    logic [ROW_W-1:0]           row_q;
    logic [N_DIM_ARRAY_LOG-1:0] ptr_q;
    logic [CNT_W-1:0]           remaining_q;
    logic [CNT_W-1:0]           shift_q;
    logic [CNT_W-1:0]           beat_k;
    logic [CNT_W-1:0]           shift_eff;
    logic                       pass_mode;
    logic                       load_acc;
    logic                       beat_acc;
    logic                       row_done;

    function automatic logic [CNT_W-1:0] clamp_shift(input logic [MAXIMUM_DILATION_BITS-1:0] s);
        if (s == '0)
            return CNT_W'(1);
        if (s > MAXIMUM_DILATION_BITS'(N_DIM_ARRAY))
            return CNT_W'(N_DIM_ARRAY);
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        pass_mode = 1'b0;
        case (mode)
            MODE_FC, MODE_EWS: pass_mode = 1'b1;
            MODE_CNN:          pass_mode = 1'b0;
            default:           pass_mode = 1'b0;
        endcase
    end

    // Pass-through modes are a whole-row beat, so they reuse the drain path with shift = N.
    assign shift_eff  = pass_mode ? CNT_W'(N_DIM_ARRAY) : clamp_shift(shift_output_buffer);
    assign beat_k     = (shift_q < remaining_q) ? shift_q : remaining_q;
    assign out_valid  = (state_q == ST_DRAIN);
    assign busy       = (state_q == ST_DRAIN);
    assign beat_acc   = out_valid && out_ready;
    assign row_done   = (remaining_q == beat_k);
    assign load_ready = (state_q == ST_IDLE) || (out_ready && (remaining_q <= shift_q));
    assign load_acc   = load && load_ready && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
            shift_q     <= CNT_W'(1);
        end else if (clear) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
        end else if (load_acc) begin
            state_q     <= ST_DRAIN;
            row_q       <= parallel_output_array;
            ptr_q       <= '0;
            remaining_q <= CNT_W'(N_DIM_ARRAY);
            shift_q     <= shift_eff;
        end else if (beat_acc) begin
            ptr_q       <= ptr_q + beat_k[N_DIM_ARRAY_LOG-1:0];
            remaining_q <= remaining_q - beat_k;
            if (row_done)
                state_q <= ST_IDLE;
        end
    end

    output_lane_select u_lane_select (
        .words         (row_q),
        .ptr           (ptr_q),
        .k             (beat_k),
        .serial_output (serial_output),
        .out_word_mask (out_word_mask)
    );

    // The mode code steers the datapath, so it must not move while a row is held.
    mode_stable_a: assert property (@(posedge clk) disable iff (!reset)
        (state_q != ST_IDLE) |-> $stable(mode));
endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Write-back side counterpart of the PE-array input buffer.
- Captures one parallel row of N_DIM_ARRAY results from the array.
- Drains that row toward activation memory as a stream of beats, with a configurable number of words per beat and a valid/ready handshake.
- In FC/EWS modes it is a registered pass-through with the same handshake.

Parameters:
- N_DIM_ARRAY, 4, number of lanes/words per row.
- N_DIM_ARRAY_LOG, 2, log2(N_DIM_ARRAY), width of the read pointer.
- OUTPUT_DATA_WIDTH, 8, signed word width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; highest priority after reset.
- mode  input  3  0=FC, 1=CNN, 3=EWS; other values behave as CNN.
- load  input  1  parallel row offered this cycle.
- load_ready  output  1  block can accept a row this cycle.
- parallel_output_array  input  N*W  row from the PE array; lane i = bits [i*W +: W].
- shift_output_buffer  input  8  words per beat, sampled at load.
- out_valid  output  1  a beat is presented.
- out_ready  input  1  sink accepts the beat.
- serial_output  output  N*W  beat data; lane j = word ptr+j; unused lanes are 0.
- out_word_mask  output  N  1 = lane j carries a valid word.
- busy  output  1  row data held (state DRAIN).

Behaviour:
- Reset values: state IDLE, ptr=0, remaining=0, stored words=0, shift_reg=1. Outputs: out_valid=0, serial_output=0, out_word_mask=0, busy=0; load_ready follows its combinational rule.
- Load handshake: a row is accepted when load && load_ready.
- CNN states:
  - IDLE: load_ready=1. On accept, register all N words, set ptr=0, remaining=N, and latch shift_reg = clamp(shift_output_buffer). Clamp rules: 0 -> 1, values above N -> N. Next state is DRAIN.
  - DRAIN: out_valid=1 (registered state, no combinational path from load). Beat size k = min(shift_reg, remaining).
  - Lane mapping: for j<k, lane j = word[ptr+j] and mask[j]=1. For j>=k, the lane is 0 and mask[j]=0.
  - On out_valid && out_ready: ptr += k and remaining -= k.
  - If remaining-k == 0, the row is done. Go to IDLE, unless load is accepted in the same cycle; then reload and stay in DRAIN.
  - load_ready in DRAIN = out_ready && (remaining <= shift_reg). This gives back-to-back rows with no bubble.
- Latency: first beat is valid the cycle after accept. A row drains in ceil(N/shift) accepted beats.
- Backpressure: with out_ready=0, the outputs hold exactly stable and load_ready=0 in DRAIN.
- FC/EWS modes:
  - Single-entry skid register.
  - load_ready = !out_valid || out_ready.
  - On accept, latch the whole row. Next cycle out_valid=1, mask all ones, serial_output = the latched row.
  - out_valid clears on handshake with no new load.
- Mode change is legal only while IDLE and empty; otherwise behaviour is undefined, and the assertion flags it.
- clear: next edge returns to IDLE, zeroes storage, ptr and remaining, and sets out_valid=0. A load in the same cycle is ignored.
- Reset mid-drain: asynchronously returns to the reset values; the pending beat is lost.
- Pointer arithmetic is modulo N in N_DIM_ARRAY_LOG bits; remaining is N_DIM_ARRAY_LOG+1 bits wide.

Decomposition:
- Shared parameters package holds:
  - N_DIM_ARRAY, N_DIM_ARRAY_LOG and OUTPUT_DATA_WIDTH.
  - MODE_FC=0, MODE_CNN=1, MODE_EWS=3.
  - MAXIMUM_DILATION_BITS=8, which sets the width of shift_output_buffer.
- One sub-module: output_lane_select. It is combinational and produces serial_output and out_word_mask from the words, ptr and k.
- State machine and counters stay in output_buffer.

Test Plan:
- CNN, shift=1, row {0x11,0x22,0x33,0x44}, out_ready=1 -> four beats; lane0 = 11, 22, 33, 44 in order; mask=0001 each; busy drops after beat 4.
- CNN, shift=3, same row -> beat1 lanes {11,22,33}, mask 0111; beat2 lane0=44, mask 0001; then IDLE.
- CNN, shift=4, out_ready toggles 1,0,1 with load held high and rows A, B -> A on cycle 1, held on cycle 2, B on cycle 3, no bubble; load_ready=0 during the stall.
- Edge shifts: shift=0 behaves as 1 (four beats); shift=9 behaves as 4 (one beat, mask 1111).
- FC mode, row {-1,2,-3,4} with out_ready=0 for 2 cycles -> out_valid stays 1, data stable, load_ready=0; accepted on release; mask 1111.
- Mid-drain events: clear asserted after beat 1 of a shift=1 row -> next cycle out_valid=0, busy=0, serial_output=0. Repeating with reset low gives the same result asynchronously.
